// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle. master = control unit, slave = datapath.
// Handshake: memready high means the memory finishes the access presented this
// cycle; the controller holds its memory selects/strobes until it sees it.
interface mc_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               memready;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [2:0]         alucontrol;
  logic               pcen;
  logic               illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal, dbg_state
  );

  modport slave (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal, dbg_state
  );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp (and funct for R-type) to the 3-bit ALU control,
// flagging any R-type funct the datapath does not implement.
module aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_funct_bad
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    o_funct_bad  = 1'b0;
    case (i_aluop)
      ALUOP_SUB:   o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_funct_bad  = 1'b1;
        endcase
      end
      default:     o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM plus output decode.
// Optional bne support is enabled by defining MC_BNE_EN.
module mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  state_t     r_state;
  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_pcwrite, w_branch, w_illegal, w_op_legal, w_take;
  logic       w_funct_bad;
  logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
  logic [2:0] w_alucontrol;

`ifdef MC_BNE_EN
  logic r_bne_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
`ifdef MC_BNE_EN
      r_bne_q <= 1'b0;
`endif
    end else begin
      case (r_state)
        FETCH:    if (bus.memready) r_state <= DECODE;
        DECODE: begin
`ifdef MC_BNE_EN
          r_bne_q <= (bus.op == OP_BNE);
`endif
          case (bus.op)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_RTYPE:     r_state <= EXECUTE;
            OP_BEQ:       r_state <= BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:       r_state <= BRANCH;
`endif
            OP_ADDI:      r_state <= ADDIEXEC;
            OP_J:         r_state <= JUMP;
            default:      r_state <= FETCH;
          endcase
        end
        MEMADR:   r_state <= (bus.op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:    if (bus.memready) r_state <= MEMWB;
        MEMWR:    if (bus.memready) r_state <= FETCH;
        EXECUTE:  r_state <= ALUWB;
        ADDIEXEC: r_state <= ADDIWB;
        default:  r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    case (bus.op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE:                                        w_op_legal = 1'b1;
`endif
      default:                                       w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = SRCB_B;
    w_pcsrc    = PCSRC_ALU;
    w_aluop    = ALUOP_ADD;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      FETCH: begin
        w_alusrcb = SRCB_FOUR;
        w_irwrite = bus.memready;
        w_pcwrite = bus.memready;
      end
      DECODE: begin
        w_alusrcb = SRCB_IMMSH;
        w_illegal = ~w_op_legal;
      end
      MEMADR, ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
      end
      MEMRD:  w_iord = 1'b1;
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_illegal = w_funct_bad;
      end
      ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = PCSRC_ALUOUT;
        w_branch  = 1'b1;
      end
      ADDIWB: w_regwrite = 1'b1;
      JUMP: begin
        w_pcsrc   = PCSRC_JUMP;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (bus.funct),
    .o_alucontrol (w_alucontrol),
    .o_funct_bad  (w_funct_bad)
  );

`ifdef MC_BNE_EN
  assign w_take = r_bne_q ? ~bus.zero : bus.zero;
`else
  assign w_take = bus.zero;
`endif

  // Strobes are gated by reset so a mid-access reset never leaks a write.
  assign bus.memwrite   = w_memwrite & reset;
  assign bus.irwrite    = w_irwrite & reset;
  assign bus.regwrite   = w_regwrite & reset;
  assign bus.illegal    = w_illegal & reset;
  assign bus.pcen       = (w_pcwrite | (w_branch & w_take)) & reset;
  assign bus.iord       = w_iord;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.alucontrol = w_alucontrol;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the
// FSM and checks state and control outputs against hand-computed values.
module tb_mc_controller;
  import mips_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mc_ctrl_if u_if ();

  mc_controller u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs after the falling edge, then let the combinational outputs settle.
  task automatic cyc(input logic mr, input logic z);
    @(negedge clk);
    u_if.memready = mr;
    u_if.zero     = z;
    #1;
  endtask

  task automatic fetch_decode();
    cyc(1'b1, 1'b0);
    chk("fd_fetch_state", 32'(u_if.dbg_state), 32'd0);
    cyc(1'b0, 1'b0);
    chk("fd_decode_state", 32'(u_if.dbg_state), 32'd1);
  endtask

  int cycles;
  int irw_cnt;
  int pce_cnt;
  int irw_cyc;
  logic mr_sched [10];

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    u_if.op       = 6'b0;
    u_if.funct    = 6'b0;
    u_if.zero     = 1'b0;
    u_if.memready = 1'b0;

    // reset state, memready high must not leak irwrite/pcen
    cyc(1'b1, 1'b0);
    chk("rst_state", 32'(u_if.dbg_state), 32'd0);
    chk("rst_irwrite", 32'(u_if.irwrite), 32'd0);
    chk("rst_pcen", 32'(u_if.pcen), 32'd0);
    chk("rst_illegal", 32'(u_if.illegal), 32'd0);
    u_if.memready = 1'b0;
    reset = 1'b1;

    // sw interrupted by reset while in MEMWR
    u_if.op = 6'b101011;
    fetch_decode();
    cyc(1'b0, 1'b0);
    chk("sw_memadr_state", 32'(u_if.dbg_state), 32'd2);
    cyc(1'b0, 1'b0);
    chk("sw_memwr_state", 32'(u_if.dbg_state), 32'd5);
    chk("sw_memwrite", 32'(u_if.memwrite), 32'd1);
    chk("sw_iord", 32'(u_if.iord), 32'd1);
    @(negedge clk);
    u_if.memready = 1'b1;
    reset = 1'b0;
    #1;
    chk("rstmid_memwrite", 32'(u_if.memwrite), 32'd0);
    chk("rstmid_state", 32'(u_if.dbg_state), 32'd0);
    chk("rstmid_irwrite", 32'(u_if.irwrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("rstmid_memwrite2", 32'(u_if.memwrite), 32'd0);
    chk("rstmid_pcen", 32'(u_if.pcen), 32'd0);
    u_if.memready = 1'b0;
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    chk("rstrel_state", 32'(u_if.dbg_state), 32'd0);

    // lw, no wait states
    u_if.op = 6'b100011;
    cyc(1'b1, 1'b0);
    chk("lw_fetch_state", 32'(u_if.dbg_state), 32'd0);
    chk("lw_fetch_irwrite", 32'(u_if.irwrite), 32'd1);
    chk("lw_fetch_pcen", 32'(u_if.pcen), 32'd1);
    chk("lw_fetch_alusrcb", 32'(u_if.alusrcb), 32'd1);
    chk("lw_fetch_iord", 32'(u_if.iord), 32'd0);
    cyc(1'b1, 1'b0);
    chk("lw_decode_state", 32'(u_if.dbg_state), 32'd1);
    chk("lw_decode_alusrcb", 32'(u_if.alusrcb), 32'd3);
    chk("lw_decode_irwrite", 32'(u_if.irwrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("lw_memadr_state", 32'(u_if.dbg_state), 32'd2);
    chk("lw_memadr_alusrca", 32'(u_if.alusrca), 32'd1);
    chk("lw_memadr_alusrcb", 32'(u_if.alusrcb), 32'd2);
    chk("lw_memadr_aluctl", 32'(u_if.alucontrol), 32'd2);
    cyc(1'b1, 1'b0);
    chk("lw_memrd_state", 32'(u_if.dbg_state), 32'd3);
    chk("lw_memrd_iord", 32'(u_if.iord), 32'd1);
    chk("lw_memrd_regwrite", 32'(u_if.regwrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("lw_memwb_state", 32'(u_if.dbg_state), 32'd4);
    chk("lw_memwb_regwrite", 32'(u_if.regwrite), 32'd1);
    chk("lw_memwb_memtoreg", 32'(u_if.memtoreg), 32'd1);
    chk("lw_memwb_regdst", 32'(u_if.regdst), 32'd0);
    cyc(1'b0, 1'b0);
    chk("lw_done_state", 32'(u_if.dbg_state), 32'd0);

    // lw with 2 wait cycles in FETCH and 3 in MEMRD: 10 cycles
    mr_sched = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    cycles  = 0;
    irw_cnt = 0;
    pce_cnt = 0;
    irw_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      cyc((i < 10) ? mr_sched[i] : 1'b0, 1'b0);
      cycles++;
      if (u_if.irwrite) begin
        irw_cnt++;
        irw_cyc = cycles;
      end
      if (u_if.pcen) pce_cnt++;
      if (u_if.dbg_state == 4'd4) break;
    end
    chk("lwwait_cycles", 32'(cycles), 32'd10);
    chk("lwwait_irw_cnt", 32'(irw_cnt), 32'd1);
    chk("lwwait_pcen_cnt", 32'(pce_cnt), 32'd1);
    chk("lwwait_irw_cyc", 32'(irw_cyc), 32'd3);
    cyc(1'b0, 1'b0);
    chk("lwwait_done_state", 32'(u_if.dbg_state), 32'd0);

    // beq taken and not taken
    u_if.op = 6'b000100;
    fetch_decode();
    cyc(1'b0, 1'b1);
    chk("beq_t_state", 32'(u_if.dbg_state), 32'd8);
    chk("beq_t_pcen", 32'(u_if.pcen), 32'd1);
    chk("beq_t_pcsrc", 32'(u_if.pcsrc), 32'd1);
    chk("beq_t_aluctl", 32'(u_if.alucontrol), 32'd6);
    fetch_decode();
    cyc(1'b0, 1'b0);
    chk("beq_nt_state", 32'(u_if.dbg_state), 32'd8);
    chk("beq_nt_pcen", 32'(u_if.pcen), 32'd0);

    // R-type slt, then an unsupported funct
    u_if.op    = 6'b000000;
    u_if.funct = 6'b101010;
    fetch_decode();
    cyc(1'b0, 1'b0);
    chk("slt_exec_state", 32'(u_if.dbg_state), 32'd6);
    chk("slt_exec_aluctl", 32'(u_if.alucontrol), 32'd7);
    chk("slt_exec_illegal", 32'(u_if.illegal), 32'd0);
    cyc(1'b0, 1'b0);
    chk("slt_wb_regwrite", 32'(u_if.regwrite), 32'd1);
    chk("slt_wb_regdst", 32'(u_if.regdst), 32'd1);
    chk("slt_wb_memtoreg", 32'(u_if.memtoreg), 32'd0);
    u_if.funct = 6'b000111;
    fetch_decode();
    cyc(1'b0, 1'b0);
    chk("badf_exec_illegal", 32'(u_if.illegal), 32'd1);
    chk("badf_exec_aluctl", 32'(u_if.alucontrol), 32'd2);
    cyc(1'b0, 1'b0);
    chk("badf_wb_regwrite", 32'(u_if.regwrite), 32'd1);
    chk("badf_wb_illegal", 32'(u_if.illegal), 32'd0);

    // addi
    u_if.op = 6'b001000;
    fetch_decode();
    cyc(1'b0, 1'b0);
    chk("addi_exec_state", 32'(u_if.dbg_state), 32'd9);
    chk("addi_exec_alusrcb", 32'(u_if.alusrcb), 32'd2);
    cyc(1'b0, 1'b0);
    chk("addi_wb_state", 32'(u_if.dbg_state), 32'd10);
    chk("addi_wb_regwrite", 32'(u_if.regwrite), 32'd1);
    chk("addi_wb_regdst", 32'(u_if.regdst), 32'd0);

    // j
    u_if.op = 6'b000010;
    fetch_decode();
    cyc(1'b0, 1'b0);
    chk("j_state", 32'(u_if.dbg_state), 32'd11);
    chk("j_pcen", 32'(u_if.pcen), 32'd1);
    chk("j_pcsrc", 32'(u_if.pcsrc), 32'd2);

    // op 000101 (bne)
    u_if.op = 6'b000101;
`ifdef MC_BNE_EN
    fetch_decode();
    chk("bne_decode_illegal", 32'(u_if.illegal), 32'd0);
    cyc(1'b0, 1'b0);
    chk("bne_t_state", 32'(u_if.dbg_state), 32'd8);
    chk("bne_t_pcen", 32'(u_if.pcen), 32'd1);
    fetch_decode();
    cyc(1'b0, 1'b1);
    chk("bne_nt_pcen", 32'(u_if.pcen), 32'd0);
`else
    fetch_decode();
    chk("bne_decode_illegal", 32'(u_if.illegal), 32'd1);
    chk("bne_decode_regwrite", 32'(u_if.regwrite), 32'd0);
    chk("bne_decode_memwrite", 32'(u_if.memwrite), 32'd0);
    chk("bne_decode_pcen", 32'(u_if.pcen), 32'd0);
    cyc(1'b0, 1'b0);
    chk("bne_next_state", 32'(u_if.dbg_state), 32'd0);
    chk("bne_next_illegal", 32'(u_if.illegal), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
